// File: rtl/axi_ni_target_send.sv
// Target-side NI response path: arbitrates AXI B and R responses and serializes each
// into a NoC response packet, pulsing a per-ID completion strobe when the packet is done.
module axi_ni_target_send #(
    parameter int FLIT_WIDTH        = 32,
    parameter int AXIRDATAWD        = 32,
    parameter int IDWD              = 4,
    parameter int SOURCEWD          = 8,
    parameter int MAX_SUPPORTED_IDS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         src_wr,
    input  logic [IDWD-1:0]              src_wr_id,
    input  logic [SOURCEWD-1:0]          src_wr_source,
    input  logic [IDWD-1:0]              BID,
    input  logic [1:0]                   BRESP,
    input  logic                         BVALID,
    output logic                         BREADY,
    input  logic [IDWD-1:0]              RID,
    input  logic [AXIRDATAWD-1:0]        RDATA,
    input  logic [1:0]                   RRESP,
    input  logic                         RLAST,
    input  logic                         RVALID,
    output logic                         RREADY,
    output logic [FLIT_WIDTH-1:0]        flit,
    output logic                         valid,
    input  logic                         stall,
    output logic [MAX_SUPPORTED_IDS-1:0] wrr_rinc,
    output logic [MAX_SUPPORTED_IDS-1:0] rdr_rinc
);
    localparam int P       = AXIRDATAWD / 16;
    localparam int CNTW    = (P > 1) ? $clog2(P) : 1;
    localparam int HDR_PAD = FLIT_WIDTH - 2 - SOURCEWD - IDWD - 4;
    localparam int PAY_PAD = FLIT_WIDTH - 18;

    typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_PAY, DONE} state_t;

    state_t                state_reg, state_next;
    logic                  ptr_reg, ptr_next;     // 0 favours B, 1 favours R
    logic [CNTW-1:0]       cnt_reg, cnt_next;
    logic [SOURCEWD-1:0]   src_table_reg [MAX_SUPPORTED_IDS];

    logic [IDWD-1:0]       id_reg;
    logic [1:0]            resp_reg;
    logic                  last_reg;
    logic                  is_read_reg;
    logic [SOURCEWD-1:0]   dest_reg;
    logic [AXIRDATAWD-1:0] data_reg;

    logic                  grant_b, grant_r, cap_b, cap_r;
    logic [15:0]           pay_hw [P];
    logic [MAX_SUPPORTED_IDS-1:0] id_onehot;
    logic                  last_pay;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_pay
            assign pay_hw[gi] = data_reg[gi*16 +: 16];
        end
        for (gi = 0; gi < MAX_SUPPORTED_IDS; gi++) begin : g_onehot
            assign id_onehot[gi] = (id_reg == IDWD'(gi));
        end
    endgenerate

    // Lookups at capture see the pre-write table contents on a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_SUPPORTED_IDS; i++)
                src_table_reg[i] <= '0;
        end else if (src_wr) begin
            src_table_reg[src_wr_id] <= src_wr_source;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_reg      <= '0;
            resp_reg    <= '0;
            last_reg    <= 1'b0;
            is_read_reg <= 1'b0;
            dest_reg    <= '0;
            data_reg    <= '0;
        end else if (cap_b) begin
            id_reg      <= BID;
            resp_reg    <= BRESP;
            last_reg    <= 1'b1;
            is_read_reg <= 1'b0;
            dest_reg    <= src_table_reg[BID];
        end else if (cap_r) begin
            id_reg      <= RID;
            resp_reg    <= RRESP;
            last_reg    <= RLAST;
            is_read_reg <= 1'b1;
            dest_reg    <= src_table_reg[RID];
            data_reg    <= RDATA;
        end
    end

    assign last_pay = (cnt_reg == CNTW'(P - 1));

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        grant_b    = 1'b0;
        grant_r    = 1'b0;
        cap_b      = 1'b0;
        cap_r      = 1'b0;
        valid      = 1'b0;
        flit       = '0;
        case (state_reg)
            IDLE: begin
                if (BVALID && RVALID) begin
                    grant_b  = ~ptr_reg;
                    grant_r  = ptr_reg;
                    ptr_next = ~ptr_reg;
                end else begin
                    grant_b = BVALID;
                    grant_r = RVALID;
                end
                cap_b = grant_b && BVALID;
                cap_r = grant_r && RVALID;
                if (cap_b || cap_r)
                    state_next = SEND_HDR;
            end
            SEND_HDR: begin
                valid = 1'b1;
                flit  = {(is_read_reg ? 2'b01 : 2'b11), dest_reg, id_reg, resp_reg,
                         is_read_reg, last_reg, {HDR_PAD{1'b0}}};
                if (!stall) begin
                    if (is_read_reg) begin
                        state_next = SEND_PAY;
                        cnt_next   = '0;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SEND_PAY: begin
                valid = 1'b1;
                flit  = {(last_pay ? 2'b10 : 2'b00), {PAY_PAD{1'b0}}, pay_hw[cnt_reg]};
                if (!stall) begin
                    cnt_next = cnt_reg + CNTW'(1);
                    if (last_pay)
                        state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign BREADY   = grant_b;
    assign RREADY   = grant_r;
    // A non-last read beat leaves the ID outstanding until its final beat is sent.
    assign wrr_rinc = (state_reg == DONE && !is_read_reg) ? id_onehot : '0;
    assign rdr_rinc = (state_reg == DONE && is_read_reg && last_reg) ? id_onehot : '0;

endmodule

// File: tb/tb_axi_ni_target_send.sv
// Directed bench for axi_ni_target_send: write/read packets, stall hold, B/R alternation,
// same-cycle table write and mid-packet reset.
module tb_axi_ni_target_send;
    logic        clk = 1'b0;
    logic        rst;
    logic        src_wr;
    logic [3:0]  src_wr_id;
    logic [7:0]  src_wr_source;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] flit;
    logic        valid;
    logic        stall;
    logic [15:0] wrr_rinc;
    logic [15:0] rdr_rinc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_ni_target_send dut (
        .clk(clk), .rst(rst),
        .src_wr(src_wr), .src_wr_id(src_wr_id), .src_wr_source(src_wr_source),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .flit(flit), .valid(valid), .stall(stall),
        .wrr_rinc(wrr_rinc), .rdr_rinc(rdr_rinc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'h0);
        chk({tag, "_flit"}, flit, 32'h0);
        chk({tag, "_wrr"}, 32'(wrr_rinc), 32'h0);
        chk({tag, "_rdr"}, 32'(rdr_rinc), 32'h0);
    endtask

    initial begin
        rst = 1'b1; src_wr = 1'b0; src_wr_id = '0; src_wr_source = '0;
        BID = '0; BRESP = '0; BVALID = 1'b0;
        RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        stall = 1'b0;
        tick(); tick();
        chk_idle_out("reset");
        chk("reset_bready", 32'(BREADY), 32'h0);
        chk("reset_rready", 32'(RREADY), 32'h0);
        rst = 1'b0;
        tick();

        // Write response, id 3 -> source 0x5A
        src_wr = 1'b1; src_wr_id = 4'd3; src_wr_source = 8'h5A;
        tick();
        src_wr = 1'b0;
        BVALID = 1'b1; BID = 4'd3; BRESP = 2'b00;
        #1;
        chk("wr_bready", 32'(BREADY), 32'h1);
        chk("wr_rready", 32'(RREADY), 32'h0);
        tick();
        BVALID = 1'b0;
        chk("wr_hdr_valid", 32'(valid), 32'h1);
        chk("wr_hdr", flit, 32'hD68C4000);
        chk("wr_bready_busy", 32'(BREADY), 32'h0);
        tick();
        chk("wr_done_valid", 32'(valid), 32'h0);
        chk("wr_rinc", 32'(wrr_rinc), 32'h0008);
        chk("wr_rdr", 32'(rdr_rinc), 32'h0);
        tick();
        chk_idle_out("wr_after");
        $display("txn write id=3 resp=0 done");

        // Read beat, id 2 -> source 0x11, last
        src_wr = 1'b1; src_wr_id = 4'd2; src_wr_source = 8'h11;
        tick();
        src_wr = 1'b0;
        RVALID = 1'b1; RID = 4'd2; RDATA = 32'hCAFEBABE; RRESP = 2'b00; RLAST = 1'b1;
        #1;
        chk("rd_rready", 32'(RREADY), 32'h1);
        chk("rd_bready", 32'(BREADY), 32'h0);
        tick();
        RVALID = 1'b0;
        chk("rd_hdr", flit, 32'h4448C000);
        tick();
        chk("rd_pay0", flit, 32'h0000BABE);
        chk("rd_pay0_valid", 32'(valid), 32'h1);
        tick();
        chk("rd_pay1", flit, 32'h8000CAFE);
        tick();
        chk("rd_done_valid", 32'(valid), 32'h0);
        chk("rd_rinc", 32'(rdr_rinc), 32'h0004);
        chk("rd_wrr", 32'(wrr_rinc), 32'h0);
        tick();
        $display("txn read id=2 last=1 done");

        // Non-last read beat with a 4-cycle stall on the first payload flit
        RVALID = 1'b1; RID = 4'd2; RDATA = 32'h12345678; RRESP = 2'b10; RLAST = 1'b0;
        tick();
        RVALID = 1'b0;
        chk("nl_hdr", flit, 32'h444A8000);
        tick();
        chk("nl_pay0", flit, 32'h00005678);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nl_stall_valid", 32'(valid), 32'h1);
            chk("nl_stall_flit", flit, 32'h00005678);
        end
        stall = 1'b0;
        tick();
        chk("nl_pay1", flit, 32'h80001234);
        tick();
        chk("nl_done_valid", 32'(valid), 32'h0);
        chk("nl_rdr", 32'(rdr_rinc), 32'h0);
        chk("nl_wrr", 32'(wrr_rinc), 32'h0);
        tick();
        $display("txn read id=2 last=0 stalled done");

        // Both channels valid: B, R, B alternation
        BVALID = 1'b1; BID = 4'd5; BRESP = 2'b01;
        RVALID = 1'b1; RID = 4'd6; RDATA = 32'hA5A55A5A; RRESP = 2'b00; RLAST = 1'b1;
        #1;
        chk("arb1_bready", 32'(BREADY), 32'h1);
        chk("arb1_rready", 32'(RREADY), 32'h0);
        tick();
        chk("arb1_hdr", flit, 32'hC0154000);
        chk("arb1_rready_busy", 32'(RREADY), 32'h0);
        tick();
        chk("arb1_wrr", 32'(wrr_rinc), 32'h0020);
        tick();
        chk("arb2_rready", 32'(RREADY), 32'h1);
        chk("arb2_bready", 32'(BREADY), 32'h0);
        tick();
        chk("arb2_hdr", flit, 32'h4018C000);
        chk("arb2_bready_busy", 32'(BREADY), 32'h0);
        tick();
        chk("arb2_pay0", flit, 32'h00005A5A);
        tick();
        chk("arb2_pay1", flit, 32'h8000A5A5);
        tick();
        chk("arb2_rdr", 32'(rdr_rinc), 32'h0040);
        tick();
        chk("arb3_bready", 32'(BREADY), 32'h1);
        chk("arb3_rready", 32'(RREADY), 32'h0);
        tick();
        BVALID = 1'b0;
        chk("arb3_hdr", flit, 32'hC0154000);
        tick();
        chk("arb3_wrr", 32'(wrr_rinc), 32'h0020);
        $display("txn arbitration B,R,B done");

        // Read id 6, reset during first payload flit
        tick();
        chk("rst_rready", 32'(RREADY), 32'h1);
        tick();
        RVALID = 1'b0;
        chk("rst_hdr", flit, 32'h4018C000);
        tick();
        chk("rst_pay0", flit, 32'h00005A5A);
        rst = 1'b1;
        #1;
        chk_idle_out("rst_async");
        tick();
        chk_idle_out("rst_hold");
        tick();
        rst = 1'b0;
        $display("txn reset mid-packet");

        // Pointer back to B; table cleared; same-cycle table write not visible
        BVALID = 1'b1; BID = 4'd3; BRESP = 2'b00;
        RVALID = 1'b1;
        src_wr = 1'b1; src_wr_id = 4'd3; src_wr_source = 8'h77;
        #1;
        chk("post_bready", 32'(BREADY), 32'h1);
        chk("post_rready", 32'(RREADY), 32'h0);
        tick();
        src_wr = 1'b0; BVALID = 1'b0; RVALID = 1'b0;
        chk("post_hdr", flit, 32'hC00C4000);
        tick();
        chk("post_wrr", 32'(wrr_rinc), 32'h0008);
        tick();
        $display("txn write id=3 after reset done");

        BVALID = 1'b1; BID = 4'd3; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        chk("rbw_hdr", flit, 32'hDDCC4000);
        tick();
        chk("rbw_wrr", 32'(wrr_rinc), 32'h0008);
        tick();
        chk_idle_out("final");
        $display("txn write id=3 updated source done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
